// File: rtl/cs_pkg.sv
// Shared types and sizing helpers for the sequential carry-save resolver.
package cs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice cycles needed to cover the WIDTH+3 bit result.
    function automatic int nslice(input int width, input int slice);
        return (width + 3 + slice - 1) / slice;
    endfunction

    function automatic int result_width(input int width);
        return width + 3;
    endfunction

endpackage

// File: rtl/cs_slice_adder.sv
// One SLICE-bit step of the resolver: a + b + d + cin, with a 2-bit carry out (0..2).
module cs_slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [SLICE-1:0] d,
    input  logic [1:0]       cin,
    output logic [SLICE-1:0] sum,
    output logic [1:0]       cout
);

    logic [SLICE+1:0] w_total;

    assign w_total = {2'b00, a} + {2'b00, b} + {2'b00, d} + {{SLICE{1'b0}}, cin};
    assign {cout, sum} = w_total;

endmodule

// File: rtl/cs_resolver.sv
// Sequential carry-propagate back end: resolves s + 2c + 2cout one SLICE per cycle
// behind valid/ready handshakes on both sides.
module cs_resolver
    import cs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                s,
    input  logic [WIDTH-1:0]                c,
    input  logic [WIDTH-1:0]                cout,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [result_width(WIDTH)-1:0]  result,
    output logic                            busy
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int RW     = result_width(WIDTH);
    localparam int TOT    = NSLICE * SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [TOT-1:0]   r_a;
    logic [TOT-1:0]   r_b;
    logic [TOT-1:0]   r_d;
    logic [TOT-1:0]   r_acc;
    logic [1:0]       r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic [SLICE-1:0] w_sum;
    logic [1:0]       w_carry;

    cs_slice_adder #(.SLICE(SLICE)) u_adder (
        .a    (r_a[SLICE-1:0]),
        .b    (r_b[SLICE-1:0]),
        .d    (r_d[SLICE-1:0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_CNT) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_state_next = in_valid ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // Operands are zero-extended; c and cout carry weight 2, hence the shifted-in zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_acc   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= {{(TOT - WIDTH){1'b0}}, s};
            r_b     <= {{(TOT - WIDTH - 1){1'b0}}, c, 1'b0};
            r_d     <= {{(TOT - WIDTH - 1){1'b0}}, cout, 1'b0};
            r_carry <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_d     <= r_d >> SLICE;
            r_acc   <= {w_sum, r_acc[TOT-1:SLICE]};
            r_carry <= w_carry;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign result = r_acc[RW-1:0];

    a_final_carry_zero: assert property (@(posedge clk) disable iff (rst)
        (r_state == RUN && r_cnt == LAST_CNT) |=> (r_carry == 2'b00));

    generate
        if (TOT > RW) begin : g_upper_zero
            a_upper_bits_zero: assert property (@(posedge clk) disable iff (rst)
                (r_state == DONE) |-> (r_acc[TOT-1:RW] == '0));
        end
    endgenerate

endmodule

// File: tb/tb_cs_resolver.sv
// Scoreboard bench for cs_resolver: driver pushes s+2c+2cout on accept, monitor pops on output.
module tb_cs_resolver;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = 5;
    localparam int RW     = WIDTH + 3;

    typedef struct {
        logic [RW-1:0] val;
        int            vcyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s, c, cout;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    result;
    logic             busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   cyc      = 0;
    int   or_mode  = 1;   // 0 random, 1 force high, 2 force low
    logic prev_valid = 1'b0;

    cs_resolver #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .c         (c),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] ts, tc, tco);
        longint v;
        v = longint'(ts) + 2 * longint'(tc) + 2 * longint'(tco);
        return RW'(v);
    endfunction

    // Hold the triple until accepted; inputs are driven at negedge and sampled just before posedge.
    task automatic send(input logic [WIDTH-1:0] ts, tc, tco);
        int  waited = 0;
        bit  done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1; s = ts; c = tc; cout = tco;
            #4;
            if (in_ready) begin
                sb.push_back('{val: model(ts, tc, tco), vcyc: cyc + NSLICE + 1});
                n_pushed++;
                done = 1'b1;
            end else if (++waited > 200) begin
                n_checks++;
                $display("FAIL accept_timeout: actual=no_accept required=accept");
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            s = $urandom; c = $urandom; cout = $urandom;
        end
    endtask

    task automatic wait_valid();
        int waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk); #4;
            waited++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL valid_timeout: actual=0 required=1");
        end
    endtask

    task automatic drain(input int budget);
        int waited = 0;
        while (sb.size() != 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("sb_drained", sb.size(), 0);
    endtask

    // Monitor: drives out_ready, checks latency on each rising out_valid, pops on handshake.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (or_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            #3;
            if (!rst) begin
                if (out_valid && !prev_valid && sb.size() != 0)
                    check("latency", cyc, sb[0].vcyc);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL spurious_result: actual=%0h required=none", result);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        n_popped++;
                        check("result", result, e.val);
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; s = '0; c = '0; cout = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed corner values
        or_mode = 1;
        send(32'h0, 32'h0, 32'h0);
        idle(1);
        send(32'h000000FF, 32'h00000080, 32'h00000001);
        idle(1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idle(1);
        drain(100);

        // Back-pressure: result and out_valid hold, in_ready stays low
        or_mode = 2;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idle(1);
        check("busy_in_run", busy, 1);
        wait_valid();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #4;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, 35'h4_FFFF_FFFB);
        end
        or_mode = 1;
        send(32'd3, 32'd1, 32'd1);
        idle(1);
        drain(100);

        // Randomized traffic with gaps on both sides
        or_mode = 0;
        for (int i = 0; i < 20; i++) begin
            send($urandom, $urandom, $urandom);
            idle($urandom_range(0, 3));
        end
        or_mode = 1;
        drain(500);

        // Reset in the middle of RUN discards the operation
        send($urandom, $urandom, $urandom);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        sb.delete();
        n_pushed--;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(32'd5, 32'd0, 32'd0);
        idle(1);
        drain(100);

        check("pushed_eq_popped", n_popped, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
